// File: rtl/cordic_ctrl_pkg.sv
// rtl/cordic_ctrl_pkg.sv - state encoding and angle region limits for the CORDIC request controller
package cordic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_START,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } ctrl_state_e;

  // IEEE-754 bit patterns of pi/2, pi, 3pi/2 and 2pi; positive floats order like unsigned ints
  localparam logic [63:0] SP_PI_2  = 64'h0000_0000_3FC9_0FDB;
  localparam logic [63:0] SP_PI    = 64'h0000_0000_4049_0FDB;
  localparam logic [63:0] SP_PI3_2 = 64'h0000_0000_4096_CBE4;
  localparam logic [63:0] SP_TWO_PI = 64'h0000_0000_40C9_0FDB;

  localparam logic [63:0] DP_PI_2  = 64'h3FF9_21FB_5444_2D18;
  localparam logic [63:0] DP_PI    = 64'h4009_21FB_5444_2D18;
  localparam logic [63:0] DP_PI3_2 = 64'h4012_D97C_7F33_21D2;
  localparam logic [63:0] DP_TWO_PI = 64'h4019_21FB_5444_2D18;

endpackage

// File: rtl/cordic_region_classify.sv
// rtl/cordic_region_classify.sv - magnitude compare giving the CORDIC shift region and an illegal-angle flag
module cordic_region_classify
  import cordic_ctrl_pkg::*;
#(
  parameter int W     = 32,
  parameter int W_Exp = 8,
  parameter int W_Sgf = 23
) (
  input  logic [W-2:0] magnitude,
  output logic [1:0]   region,
  output logic         illegal
);

  localparam logic [63:0] LIM0_64 = (W == 64) ? DP_PI_2   : SP_PI_2;
  localparam logic [63:0] LIM1_64 = (W == 64) ? DP_PI     : SP_PI;
  localparam logic [63:0] LIM2_64 = (W == 64) ? DP_PI3_2  : SP_PI3_2;
  localparam logic [63:0] LIM3_64 = (W == 64) ? DP_TWO_PI : SP_TWO_PI;

  localparam logic [W-1:0] LIM0 = LIM0_64[W-1:0];
  localparam logic [W-1:0] LIM1 = LIM1_64[W-1:0];
  localparam logic [W-1:0] LIM2 = LIM2_64[W-1:0];
  localparam logic [W-1:0] LIM3 = LIM3_64[W-1:0];

  logic [W-1:0] mag;
  logic         exp_ones;

  always_comb begin
    mag      = {1'b0, magnitude};
    exp_ones = &magnitude[W_Sgf +: W_Exp];
    region   = 2'b11;
    if (mag < LIM0) begin
      region = 2'b00;
    end else if (mag < LIM1) begin
      region = 2'b01;
    end else if (mag < LIM2) begin
      region = 2'b10;
    end
    illegal = exp_ones || (mag >= LIM3);
  end

endmodule

// File: rtl/cordic_request_ctrl.sv
// rtl/cordic_request_ctrl.sv - request/response controller wrapping the sine/cosine CORDIC start/ack handshake
module cordic_request_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int W       = 32,
  parameter int W_Exp   = 8,
  parameter int W_Sgf   = 23,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_operation,
  input  logic [W-1:0] req_angle,
  output logic         beg_fsm_cordic,
  output logic         operation,
  output logic [W-1:0] data_in,
  output logic [1:0]   shift_region_flag,
  input  logic         ready_cordic,
  input  logic [W-1:0] data_output,
  input  logic         overflow_flag,
  input  logic         underflow_flag,
  output logic         ack_cordic,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_overflow,
  output logic         res_underflow,
  output logic         res_error,
  output logic         busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  ctrl_state_e      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       region;
  logic             illegal;

  // Classification works on the captured angle, so the sign never affects the region
  cordic_region_classify #(
    .W     (W),
    .W_Exp (W_Exp),
    .W_Sgf (W_Sgf)
  ) u_classify (
    .magnitude (data_in[W-2:0]),
    .region    (region),
    .illegal   (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      wait_cnt          <= '0;
      req_ready         <= 1'b1;
      busy              <= 1'b0;
      beg_fsm_cordic    <= 1'b0;
      ack_cordic        <= 1'b0;
      operation         <= 1'b0;
      data_in           <= '0;
      shift_region_flag <= 2'b00;
      res_valid         <= 1'b0;
      res_data          <= '0;
      res_overflow      <= 1'b0;
      res_underflow     <= 1'b0;
      res_error         <= 1'b0;
    end else begin
      beg_fsm_cordic <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            data_in       <= req_angle;
            operation     <= req_operation;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            res_data      <= '0;
            res_error     <= 1'b0;
            res_overflow  <= 1'b0;
            res_underflow <= 1'b0;
            state         <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          shift_region_flag <= region;
          if (illegal) begin
            res_error <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            beg_fsm_cordic <= 1'b1;
            state          <= ST_START;
          end
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (ready_cordic) begin
            res_data      <= data_output;
            res_overflow  <= overflow_flag;
            res_underflow <= underflow_flag;
            ack_cordic    <= 1'b1;
            state         <= ST_ACK;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            // Hung core: report an error without ever acknowledging it
            res_error <= 1'b1;
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_ACK: begin
          if (!ready_cordic) begin
            ack_cordic <= 1'b0;
            res_valid  <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_request_ctrl.sv
// tb/tb_cordic_request_ctrl.sv - directed self-checking bench for cordic_request_ctrl
module tb_cordic_request_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_operation;
  logic [W-1:0]  req_angle;
  logic          beg_fsm_cordic;
  logic          operation;
  logic [W-1:0]  data_in;
  logic [1:0]    shift_region_flag;
  logic          ready_cordic;
  logic [W-1:0]  data_output;
  logic          overflow_flag;
  logic          underflow_flag;
  logic          ack_cordic;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_overflow;
  logic          res_underflow;
  logic          res_error;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  cordic_request_ctrl #(
    .W(32), .W_Exp(8), .W_Sgf(23), .TIMEOUT(20), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operation(req_operation), .req_angle(req_angle),
    .beg_fsm_cordic(beg_fsm_cordic), .operation(operation),
    .data_in(data_in), .shift_region_flag(shift_region_flag),
    .ready_cordic(ready_cordic), .data_output(data_output),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .ack_cordic(ack_cordic), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_overflow(res_overflow),
    .res_underflow(res_underflow), .res_error(res_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, req_ready, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " beg"}, beg_fsm_cordic, 0);
    check({tag, " ack"}, ack_cordic, 0);
    check({tag, " res_valid"}, res_valid, 0);
    check({tag, " res_error"}, res_error, 0);
    check({tag, " res_data"}, res_data, 0);
    check({tag, " data_in"}, data_in, 0);
    check({tag, " region"}, shift_region_flag, 0);
    check({tag, " operation"}, operation, 0);
  endtask

  task automatic accept(input logic [31:0] angle, input logic op);
    req_angle     = angle;
    req_operation = op;
    req_valid     = 1'b1;
    tick();
    req_valid = 1'b0;
    check("accept busy", busy, 1);
    check("accept req_ready", req_ready, 0);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release res_valid", res_valid, 0);
    check("release req_ready", req_ready, 1);
    check("release busy", busy, 0);
  endtask

  task automatic run_ok(input logic [31:0] angle, input logic op, input logic [1:0] region,
                        input logic [31:0] result, input logic ovf, input logic unf,
                        input int len, input int hold, input logic early);
    accept(angle, op);
    if (early) ready_cordic = 1'b1;
    tick();
    check("start beg", beg_fsm_cordic, 1);
    check("start region", shift_region_flag, region);
    check("start data_in", data_in, angle);
    check("start operation", operation, op);
    tick();
    check("wait beg low", beg_fsm_cordic, 0);
    if (early) begin
      ready_cordic = 1'b0;
      tick();
      check("early ready ignored", ack_cordic, 0);
    end
    ready_cordic   = 1'b1;
    data_output    = result;
    overflow_flag  = ovf;
    underflow_flag = unf;
    for (int i = 0; i < len; i++) begin
      tick();
      check("ack high", ack_cordic, 1);
      check("ack res_valid low", res_valid, 0);
    end
    check("ack region stable", shift_region_flag, region);
    check("ack data_in stable", data_in, angle);
    ready_cordic   = 1'b0;
    data_output    = 32'hDEAD_BEEF;
    overflow_flag  = 1'b0;
    underflow_flag = 1'b0;
    tick();
    check("hold ack low", ack_cordic, 0);
    check("hold res_valid", res_valid, 1);
    check("hold res_data", res_data, result);
    check("hold res_overflow", res_overflow, ovf);
    check("hold res_underflow", res_underflow, unf);
    check("hold res_error", res_error, 0);
    req_valid = 1'b1;
    req_angle = 32'h3F00_0000;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("stall res_valid", res_valid, 1);
      check("stall res_data", res_data, result);
      check("stall req_ready", req_ready, 0);
      check("stall data_in", data_in, angle);
    end
    req_valid = 1'b0;
    release_result();
  endtask

  task automatic run_bad(input logic [31:0] angle);
    accept(angle, 1'b1);
    tick();
    check("illegal beg", beg_fsm_cordic, 0);
    check("illegal res_valid", res_valid, 1);
    check("illegal res_error", res_error, 1);
    check("illegal res_data", res_data, 0);
    tick();
    check("illegal beg later", beg_fsm_cordic, 0);
    release_result();
  endtask

  initial begin
    logic ack_seen;
    rst = 1'b1; req_valid = 1'b0; req_operation = 1'b0; req_angle = '0;
    ready_cordic = 1'b0; data_output = '0; overflow_flag = 1'b0;
    underflow_flag = 1'b0; res_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    run_ok(32'h3F80_0000, 1'b1, 2'b00, 32'h3F57_6AA4, 1'b0, 1'b0, 1, 0, 1'b0);
    run_ok(32'h4000_0000, 1'b0, 2'b01, 32'h1234_5678, 1'b0, 1'b1, 1, 0, 1'b0);
    run_ok(32'h4080_0000, 1'b1, 2'b10, 32'hBF00_0000, 1'b0, 1'b0, 2, 0, 1'b1);
    run_ok(32'hC0A0_0000, 1'b0, 2'b11, 32'h3E80_0000, 1'b0, 1'b0, 1, 0, 1'b0);
    run_ok(32'h3FC9_0FDA, 1'b1, 2'b00, 32'h0000_0001, 1'b0, 1'b0, 1, 0, 1'b0);
    run_ok(32'hBFC9_0FDB, 1'b1, 2'b01, 32'h0000_0002, 1'b0, 1'b0, 1, 0, 1'b0);
    run_ok(32'h40C9_0FDA, 1'b0, 2'b11, 32'h0000_0003, 1'b0, 1'b0, 1, 0, 1'b0);
    run_ok(32'h4000_0000, 1'b1, 2'b01, 32'h7F7F_FFFF, 1'b1, 1'b0, 3, 5, 1'b0);

    run_bad(32'h4282_0000);
    run_bad(32'h40C9_0FDB);
    run_bad(32'h7F80_0000);
    run_bad(32'hFFC0_0000);

    // Core never answers: 21 WAIT cycles then an error result with no ack
    accept(32'h3F80_0000, 1'b1);
    tick();
    tick();
    ack_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ack_seen |= ack_cordic;
    end
    check("timeout not early", res_valid, 0);
    tick();
    check("timeout res_valid", res_valid, 1);
    check("timeout res_error", res_error, 1);
    check("timeout res_data", res_data, 0);
    check("timeout no ack", ack_seen | ack_cordic, 0);
    release_result();

    // Reset while waiting discards the in-flight result
    accept(32'h4080_0000, 1'b1);
    tick();
    tick();
    ready_cordic = 1'b1;
    data_output  = 32'h1111_1111;
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    ready_cordic = 1'b0;
    tick();
    check("midrst idle ack", ack_cordic, 0);
    run_ok(32'h3F80_0000, 1'b1, 2'b00, 32'h3F57_6AA4, 1'b0, 1'b0, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
